// File: rtl/jtframe_keyjoy_pkg.sv
// Shared definitions for jtframe_keyjoy: PS/2 scan codes, joystick word layout,
// key latch indices and the per-player control request struct.
package jtframe_keyjoy_pkg;

    localparam logic [7:0] SC_P1_UP      = 8'h75;
    localparam logic [7:0] SC_P1_DOWN    = 8'h72;
    localparam logic [7:0] SC_P1_LEFT    = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT   = 8'h74;
    localparam logic [7:0] SC_P1_FIRE0   = 8'h14;
    localparam logic [7:0] SC_P1_FIRE1   = 8'h11;
    localparam logic [7:0] SC_P1_FIRE2   = 8'h29;
    localparam logic [7:0] SC_P1_START   = 8'h05;
    localparam logic [7:0] SC_P1_COIN    = 8'h04;
    localparam logic [7:0] SC_PAUSE      = 8'h0C;
    localparam logic [7:0] SC_SERVICE    = 8'h03;
    localparam logic [7:0] SC_P2_UP      = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN    = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT    = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT   = 8'h34;
    localparam logic [7:0] SC_P2_FIRE0   = 8'h1C;
    localparam logic [7:0] SC_P2_FIRE1   = 8'h1B;
    localparam logic [7:0] SC_P2_START   = 8'h06;
    localparam logic [7:0] SC_P2_COIN    = 8'h2E;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_START = 10;
    localparam int JOY_COIN  = 11;
    localparam int JOY_PAUSE = 12;

    localparam int KEY_NUM = 19;

    typedef enum logic [4:0] {
        K1_UP      = 5'd0,
        K1_DOWN    = 5'd1,
        K1_LEFT    = 5'd2,
        K1_RIGHT   = 5'd3,
        K1_FIRE0   = 5'd4,
        K1_FIRE1   = 5'd5,
        K1_FIRE2   = 5'd6,
        K1_START   = 5'd7,
        K1_COIN    = 5'd8,
        K1_PAUSE   = 5'd9,
        K1_SERVICE = 5'd10,
        K2_UP      = 5'd11,
        K2_DOWN    = 5'd12,
        K2_LEFT    = 5'd13,
        K2_RIGHT   = 5'd14,
        K2_FIRE0   = 5'd15,
        K2_FIRE1   = 5'd16,
        K2_START   = 5'd17,
        K2_COIN    = 5'd18,
        K_NONE     = 5'd31
    } key_e;

    typedef struct packed {
        logic [5:0] fire;
        logic       up;
        logic       down;
        logic       left;
        logic       right;
        logic       start;
        logic       coin;
        logic       pause;
    } ctrl_t;

    function automatic key_e key_decode(input logic [7:0] code);
        case (code)
            SC_P1_UP:    key_decode = K1_UP;
            SC_P1_DOWN:  key_decode = K1_DOWN;
            SC_P1_LEFT:  key_decode = K1_LEFT;
            SC_P1_RIGHT: key_decode = K1_RIGHT;
            SC_P1_FIRE0: key_decode = K1_FIRE0;
            SC_P1_FIRE1: key_decode = K1_FIRE1;
            SC_P1_FIRE2: key_decode = K1_FIRE2;
            SC_P1_START: key_decode = K1_START;
            SC_P1_COIN:  key_decode = K1_COIN;
            SC_PAUSE:    key_decode = K1_PAUSE;
            SC_SERVICE:  key_decode = K1_SERVICE;
            SC_P2_UP:    key_decode = K2_UP;
            SC_P2_DOWN:  key_decode = K2_DOWN;
            SC_P2_LEFT:  key_decode = K2_LEFT;
            SC_P2_RIGHT: key_decode = K2_RIGHT;
            SC_P2_FIRE0: key_decode = K2_FIRE0;
            SC_P2_FIRE1: key_decode = K2_FIRE1;
            SC_P2_START: key_decode = K2_START;
            SC_P2_COIN:  key_decode = K2_COIN;
            default:     key_decode = K_NONE;
        endcase
    endfunction

    function automatic int key_player(input key_e k);
        key_player = (k >= K2_UP) ? 32'sd1 : 32'sd0;
    endfunction

endpackage

// File: rtl/jtframe_keyjoy_coin.sv
// One-shot coin pulse generator: a rising request edge starts a COIN_LEN-cycle
// active-low pulse; edges during a running pulse are ignored.
module jtframe_keyjoy_coin
    import jtframe_keyjoy_pkg::*;
#(
    parameter logic [15:0] COIN_LEN = 16'd4800
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic req,
    output logic coin_n
);

    logic        req_r;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;

    // next counter value: clear, count down, or load on a fresh edge
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = 16'd0;
        end else if (cnt_r != 16'd0) begin
            cnt_nxt_s = cnt_r - 16'd1;
        end else if (req && !req_r) begin
            cnt_nxt_s = COIN_LEN;
        end else begin
            cnt_nxt_s = 16'd0;
        end
    end

    // edge register, counter and registered pulse output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r  <= 1'b0;
            cnt_r  <= 16'd0;
            coin_n <= 1'b1;
        end else begin
            req_r  <= req;
            cnt_r  <= cnt_nxt_s;
            coin_n <= (cnt_nxt_s == 16'd0);
        end
    end

endmodule

// File: rtl/jtframe_keyjoy.sv
// Merges PS/2 keys and HPS joystick words into registered active-low game controls,
// coin pulses and run/pause. Optional autofire on fire0 with JTFRAME_AUTOFIRE_EN.
module jtframe_keyjoy
    import jtframe_keyjoy_pkg::*;
#(
    parameter int          PLAYERS  = 2,
    parameter int          BUTTONS  = 2,
    parameter logic [15:0] COIN_LEN = 16'd4800,
    parameter logic [19:0] AF_DIV   = 20'd400000
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [10:0]                     ps2_key,
    input  logic [16*PLAYERS-1:0]           joy,
    input  logic                            downloading,
    input  logic                            soft_rst,
    input  logic [PLAYERS-1:0]              af_en,
    output logic [(4+BUTTONS)*PLAYERS-1:0]  joystick,
    output logic [PLAYERS-1:0]              start_n,
    output logic [PLAYERS-1:0]              coin_n,
    output logic                            service_n,
    output logic                            game_run
);

    // Player-2 keys are never latched when PLAYERS==1, so folding them onto
    // player 0 in that build only ORs in zeros.
    localparam int P2_IDX = (PLAYERS > 1) ? 1 : 0;
    localparam int W      = 4 + BUTTONS;

    logic [1:0]         rst_sync_r;
    logic               rst_int_n;
    logic               ps2_strobe_r;
    logic [KEY_NUM-1:0] key_r;
    key_e               key_sel_s;
    logic               key_hit_s;
    ctrl_t              req_s      [PLAYERS];
    logic [BUTTONS-1:0] fire_act_s [PLAYERS];
    logic               pause_any_s;
    logic               pause_r;
    logic               dl_r;
    logic               unused_s;

    // reset synchroniser: asserts immediately, releases after two clk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_r[1];

    // scan-code lookup; keys for absent players are dropped
    always_comb begin
        key_sel_s = key_decode(ps2_key[7:0]);
        key_hit_s = 1'b0;
        if (key_sel_s != K_NONE) begin
            key_hit_s = (key_player(key_sel_s) < PLAYERS);
        end else begin
            key_hit_s = 1'b0;
        end
    end

    // PS/2 strobe compare and key latches
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ps2_strobe_r <= 1'b0;
            key_r        <= '0;
        end else begin
            ps2_strobe_r <= ps2_key[10];
            if (downloading) begin
                key_r <= '0;
            end else if ((ps2_key[10] != ps2_strobe_r) && key_hit_s) begin
                key_r[key_sel_s] <= ps2_key[9];
            end else begin
                key_r <= key_r;
            end
        end
    end

    // merged active-high requests per player
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            req_s[p]       = '0;
            req_s[p].right = joy[16*p+JOY_R];
            req_s[p].left  = joy[16*p+JOY_L];
            req_s[p].down  = joy[16*p+JOY_D];
            req_s[p].up    = joy[16*p+JOY_U];
            req_s[p].start = joy[16*p+JOY_START];
            req_s[p].coin  = joy[16*p+JOY_COIN];
            req_s[p].pause = joy[16*p+JOY_PAUSE];
            for (int b = 0; b < BUTTONS; b++) begin
                req_s[p].fire[b] = joy[16*p+JOY_FIRE+b];
            end
        end
        req_s[0].up      = req_s[0].up      | key_r[K1_UP];
        req_s[0].down    = req_s[0].down    | key_r[K1_DOWN];
        req_s[0].left    = req_s[0].left    | key_r[K1_LEFT];
        req_s[0].right   = req_s[0].right   | key_r[K1_RIGHT];
        req_s[0].fire[0] = req_s[0].fire[0] | key_r[K1_FIRE0];
        req_s[0].fire[1] = req_s[0].fire[1] | key_r[K1_FIRE1];
        req_s[0].fire[2] = req_s[0].fire[2] | key_r[K1_FIRE2];
        req_s[0].start   = req_s[0].start   | key_r[K1_START];
        req_s[0].coin    = req_s[0].coin    | key_r[K1_COIN];
        req_s[0].pause   = req_s[0].pause   | key_r[K1_PAUSE];
        req_s[P2_IDX].up      = req_s[P2_IDX].up      | key_r[K2_UP];
        req_s[P2_IDX].down    = req_s[P2_IDX].down    | key_r[K2_DOWN];
        req_s[P2_IDX].left    = req_s[P2_IDX].left    | key_r[K2_LEFT];
        req_s[P2_IDX].right   = req_s[P2_IDX].right   | key_r[K2_RIGHT];
        req_s[P2_IDX].fire[0] = req_s[P2_IDX].fire[0] | key_r[K2_FIRE0];
        req_s[P2_IDX].fire[1] = req_s[P2_IDX].fire[1] | key_r[K2_FIRE1];
        req_s[P2_IDX].start   = req_s[P2_IDX].start   | key_r[K2_START];
        req_s[P2_IDX].coin    = req_s[P2_IDX].coin    | key_r[K2_COIN];
    end

`ifdef JTFRAME_AUTOFIRE_EN
    logic [19:0] af_cnt_r;
    logic        af_phase_r;

    // free-running autofire divider, phase flips every AF_DIV cycles
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            af_cnt_r   <= 20'd0;
            af_phase_r <= 1'b0;
        end else if (af_cnt_r == AF_DIV - 20'd1) begin
            af_cnt_r   <= 20'd0;
            af_phase_r <= ~af_phase_r;
        end else begin
            af_cnt_r   <= af_cnt_r + 20'd1;
        end
    end
`endif

    // fire buttons after optional autofire gating of fire0
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            fire_act_s[p] = req_s[p].fire[BUTTONS-1:0];
`ifdef JTFRAME_AUTOFIRE_EN
            if (af_en[p] && req_s[p].fire[0]) begin
                fire_act_s[p][0] = af_phase_r;
            end else begin
                fire_act_s[p][0] = req_s[p].fire[0];
            end
`else
            fire_act_s[p][0] = req_s[p].fire[0];
`endif
        end
    end

    // output register for joystick, start and service
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            joystick  <= '1;
            start_n   <= '1;
            service_n <= 1'b1;
        end else if (downloading) begin
            joystick  <= '1;
            start_n   <= '1;
            service_n <= 1'b1;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                joystick[W*p +: W] <= ~{fire_act_s[p], req_s[p].up, req_s[p].down,
                                        req_s[p].left, req_s[p].right};
                start_n[p]         <= ~req_s[p].start;
            end
            service_n <= ~key_r[K1_SERVICE];
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        jtframe_keyjoy_coin #(.COIN_LEN(COIN_LEN)) u_coin (
            .clk    (clk),
            .rst_n  (rst_int_n),
            .clr    (downloading),
            .req    (req_s[p].coin),
            .coin_n (coin_n[p])
        );
    end

    // any-player pause request
    always_comb begin
        pause_any_s = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            pause_any_s = pause_any_s | req_s[p].pause;
        end
    end

    // run/pause: download forces pause, soft reset or download end forces run
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pause_r  <= 1'b0;
            dl_r     <= 1'b0;
            game_run <= 1'b1;
        end else begin
            pause_r <= pause_any_s;
            dl_r    <= downloading;
            if (downloading) begin
                game_run <= 1'b0;
            end else if (soft_rst || dl_r) begin
                game_run <= 1'b1;
            end else if (pause_any_s && !pause_r) begin
                game_run <= ~game_run;
            end else begin
                game_run <= game_run;
            end
        end
    end

    // inputs that some configurations leave unread
    always_comb begin
        unused_s = ^{ps2_key[8], af_en, joy};
        for (int p = 0; p < PLAYERS; p++) begin
            unused_s = unused_s ^ (^req_s[p].fire);
        end
    end

endmodule

// File: tb/tb_jtframe_keyjoy.sv
// Randomised self-checking bench for jtframe_keyjoy (2-player/3-button and
// 1-player/2-button instances sharing stimulus).
module tb_jtframe_keyjoy;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic        downloading;
    logic        soft_rst;
    logic [1:0]  af_en;
    logic [13:0] joystick;
    logic [1:0]  start_n;
    logic [1:0]  coin_n;
    logic        service_n;
    logic        game_run;
    logic [5:0]  joystick1;
    logic [0:0]  start_n1;
    logic [0:0]  coin_n1;
    logic        service_n1;
    logic        game_run1;

    int checks = 0;
    int errors = 0;

    logic       pressed [256];
    logic [7:0] codes   [18] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h05, 8'h03,
                                 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h06, 8'h1A, 8'h22};

    always #5 clk = ~clk;

    jtframe_keyjoy #(.PLAYERS(2), .BUTTONS(3), .COIN_LEN(16'd4800), .AF_DIV(20'd10)) u_dut (
        .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joy(joy), .downloading(downloading),
        .soft_rst(soft_rst), .af_en(af_en), .joystick(joystick), .start_n(start_n),
        .coin_n(coin_n), .service_n(service_n), .game_run(game_run)
    );

    jtframe_keyjoy #(.PLAYERS(1), .BUTTONS(2), .COIN_LEN(16'd8), .AF_DIV(20'd10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joy(joy[15:0]), .downloading(downloading),
        .soft_rst(soft_rst), .af_en(af_en[0:0]), .joystick(joystick1), .start_n(start_n1),
        .coin_n(coin_n1), .service_n(service_n1), .game_run(game_run1)
    );

    // ctl: 0 R, 1 L, 2 D, 3 U, 4.. fire, 10 start; 8'h00 means no key
    function automatic logic [7:0] key_code(int p, int ctl);
        if (p == 0) begin
            case (ctl)
                0: return 8'h74;  1: return 8'h6B;  2: return 8'h72;  3: return 8'h75;
                4: return 8'h14;  5: return 8'h11;  6: return 8'h29;  10: return 8'h05;
                default: return 8'h00;
            endcase
        end else begin
            case (ctl)
                0: return 8'h34;  1: return 8'h23;  2: return 8'h2B;  3: return 8'h2D;
                4: return 8'h1C;  5: return 8'h1B;  10: return 8'h06;
                default: return 8'h00;
            endcase
        end
    endfunction

    function automatic logic key_on(int p, int ctl);
        logic [7:0] c;
        c = key_code(p, ctl);
        return (c != 8'h00) && pressed[c];
    endfunction

    function automatic logic [13:0] exp_joy_main();
        logic [13:0] e;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 7; i++)
                e[7*p+i] = ~(joy[16*p+i] | key_on(p, i));
        return e;
    endfunction

    function automatic logic [5:0] exp_joy_one();
        logic [5:0] e;
        for (int i = 0; i < 6; i++) e[i] = ~(joy[i] | key_on(0, i));
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) pressed[i] = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] code, input logic pr);
        @(negedge clk);
        ps2_key = {~ps2_key[10], pr, 1'b0, code};
        pressed[code] = pr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps2_key = 11'd0; joy = 32'd0; downloading = 1'b0;
        soft_rst = 1'b0; af_en = 2'b00;
        clear_model();
        repeat (3) @(negedge clk);
        checks++; if (joystick !== 14'h3FFF) begin errors++; $display("FAIL reset_joystick got %h want 3fff", joystick); end
        checks++; if (start_n !== 2'b11) begin errors++; $display("FAIL reset_start got %b want 11", start_n); end
        checks++; if (coin_n !== 2'b11) begin errors++; $display("FAIL reset_coin got %b want 11", coin_n); end
        checks++; if (service_n !== 1'b1) begin errors++; $display("FAIL reset_service got %b want 1", service_n); end
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL reset_run got %b want 1", game_run); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_joy_latency();
        @(negedge clk); joy[3] = 1'b1;
        @(negedge clk);
        checks++; if (joystick[3] !== 1'b0) begin errors++; $display("FAIL joy_up_press got %b want 0", joystick[3]); end
        joy[3] = 1'b0;
        @(negedge clk);
        checks++; if (joystick[3] !== 1'b1) begin errors++; $display("FAIL joy_up_release got %b want 1", joystick[3]); end
    endtask

    task automatic test_ps2_player2();
        send_key(8'h2D, 1'b1);
        @(negedge clk);
        checks++; if (joystick[10] !== 1'b1) begin errors++; $display("FAIL ps2_p2_early got %b want 1", joystick[10]); end
        @(negedge clk);
        checks++; if (joystick[10] !== 1'b0) begin errors++; $display("FAIL ps2_p2_up got %b want 0", joystick[10]); end
        checks++; if (joystick1 !== 6'h3F) begin errors++; $display("FAIL ps2_p2_ignored got %h want 3f", joystick1); end
        send_key(8'h2D, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (joystick[10] !== 1'b1) begin errors++; $display("FAIL ps2_p2_release got %b want 1", joystick[10]); end
    endtask

    task automatic test_random();
        logic [13:0] e_main;
        logic [5:0]  e_one;
        logic [1:0]  e_start;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                joy = $urandom & 32'hE7FF_E7FF;
            end else begin
                send_key(codes[$urandom_range(0, 17)], ($urandom_range(0, 1) == 1));
            end
            repeat (2) @(negedge clk);
            e_main  = exp_joy_main();
            e_one   = exp_joy_one();
            e_start = {~(joy[26] | key_on(1, 10)), ~(joy[10] | key_on(0, 10))};
            checks++; if (joystick !== e_main) begin errors++; $display("FAIL rand_joystick it=%0d got %h want %h", it, joystick, e_main); end
            checks++; if (start_n !== e_start) begin errors++; $display("FAIL rand_start it=%0d got %b want %b", it, start_n, e_start); end
            checks++; if (service_n !== ~pressed[8'h03]) begin errors++; $display("FAIL rand_service it=%0d got %b want %b", it, service_n, ~pressed[8'h03]); end
            checks++; if (joystick1 !== e_one) begin errors++; $display("FAIL rand_joystick1 it=%0d got %h want %h", it, joystick1, e_one); end
        end
        for (int i = 0; i < 18; i++) if (pressed[codes[i]]) send_key(codes[i], 1'b0);
        @(negedge clk); joy = 32'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_coin();
        int lows = 0, falls = 0, first_low = -1, lows1 = 0, falls1 = 0;
        logic prev = 1'b1, prev1 = 1'b1;
        send_key(8'h04, 1'b1);
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            @(negedge clk);
            if (coin_n[0] === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = cyc;
                if (prev) falls++;
            end
            if (coin_n1[0] === 1'b0) begin
                lows1++;
                if (prev1) falls1++;
            end
            prev  = coin_n[0];
            prev1 = coin_n1[0];
            if (cyc == 3000) ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h04};
            if (cyc == 3001) ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h04};
        end
        checks++; if (first_low != 2) begin errors++; $display("FAIL coin_latency got %0d want 2", first_low); end
        checks++; if (lows != 4800) begin errors++; $display("FAIL coin_length got %0d want 4800", lows); end
        checks++; if (falls != 1) begin errors++; $display("FAIL coin_pulses got %0d want 1", falls); end
        checks++; if (lows1 != 16) begin errors++; $display("FAIL coin1_length got %0d want 16", lows1); end
        checks++; if (falls1 != 2) begin errors++; $display("FAIL coin1_pulses got %0d want 2", falls1); end
        send_key(8'h04, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pause();
        send_key(8'h0C, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL pause_first got %b want 0", game_run); end
        send_key(8'h0C, 1'b0);
        send_key(8'h0C, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL pause_second got %b want 1", game_run); end
        send_key(8'h0C, 1'b0);
        repeat (2) @(negedge clk);
        joy[12] = 1'b1; soft_rst = 1'b1;
        @(negedge clk);
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL pause_softrst_prio got %b want 1", game_run); end
        joy[12] = 1'b0; soft_rst = 1'b0;
        @(negedge clk); joy[12] = 1'b1;
        @(negedge clk);
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL pause_joy got %b want 0", game_run); end
        joy[12] = 1'b0; soft_rst = 1'b1;
        @(negedge clk);
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL softrst_run got %b want 1", game_run); end
        soft_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_download();
        joy[11] = 1'b1;
        @(negedge clk);
        checks++; if (coin_n[0] !== 1'b0) begin errors++; $display("FAIL dl_coin_start got %b want 0", coin_n[0]); end
        joy[11] = 1'b0;
        send_key(8'h75, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (joystick[3] !== 1'b0) begin errors++; $display("FAIL dl_up_held got %b want 0", joystick[3]); end
        downloading = 1'b1;
        clear_model();
        @(negedge clk);
        checks++; if (joystick !== 14'h3FFF) begin errors++; $display("FAIL dl_joystick got %h want 3fff", joystick); end
        checks++; if (coin_n !== 2'b11) begin errors++; $display("FAIL dl_coin got %b want 11", coin_n); end
        checks++; if (start_n !== 2'b11 || service_n !== 1'b1) begin errors++; $display("FAIL dl_start_service got %b/%b want 11/1", start_n, service_n); end
        checks++; if (game_run !== 1'b0) begin errors++; $display("FAIL dl_run got %b want 0", game_run); end
        repeat (4) @(negedge clk);
        downloading = 1'b0;
        @(negedge clk);
        checks++; if (game_run !== 1'b1) begin errors++; $display("FAIL dl_end_run got %b want 1", game_run); end
        checks++; if (joystick !== 14'h3FFF) begin errors++; $display("FAIL dl_keys_cleared got %h want 3fff", joystick); end
        checks++; if (coin_n[0] !== 1'b1) begin errors++; $display("FAIL dl_coin_cleared got %b want 1", coin_n[0]); end
        send_key(8'h1A, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_async();
        joy[11] = 1'b1;
        @(negedge clk);
        checks++; if (coin_n[0] !== 1'b0) begin errors++; $display("FAIL arst_coin_start got %b want 0", coin_n[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (coin_n !== 2'b11) begin errors++; $display("FAIL arst_coin_clear got %b want 11", coin_n); end
        joy[11] = 1'b0;
        clear_model();
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (coin_n !== 2'b11 || game_run !== 1'b1) begin errors++; $display("FAIL arst_after got %b/%b want 11/1", coin_n, game_run); end
    endtask

    task automatic test_autofire();
        int last_t = -1;
        int ntr = 0;
        int ones = 0;
        logic prev;
        af_en = 2'b01;
        joy[4] = 1'b1;
        repeat (3) @(negedge clk);
`ifdef JTFRAME_AUTOFIRE_EN
        prev = joystick[4];
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (joystick[4] !== prev) begin
                if (last_t >= 0) begin
                    checks++; if (c - last_t != 10) begin errors++; $display("FAIL af_half_period got %0d want 10", c - last_t); end
                end
                last_t = c; ntr++; prev = joystick[4];
            end
        end
        checks++; if (ntr < 6) begin errors++; $display("FAIL af_toggles got %0d want >=6", ntr); end
        joy[4] = 1'b0;
        @(negedge clk);
        checks++; if (joystick[4] !== 1'b1) begin errors++; $display("FAIL af_release got %b want 1", joystick[4]); end
        af_en = 2'b00;
        joy[4] = 1'b1;
        repeat (2) @(negedge clk);
`else
        prev = 1'b0;
`endif
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (joystick[4] !== 1'b0) ones++;
        end
        checks++; if (ones != 0) begin errors++; $display("FAIL af_steady got %0d high samples want 0 (prev %b)", ones, prev); end
        joy[4] = 1'b0;
        @(negedge clk);
        checks++; if (joystick[4] !== 1'b1) begin errors++; $display("FAIL fire0_release got %b want 1", joystick[4]); end
        af_en = 2'b00;
    endtask

    initial begin
        test_reset();
        test_joy_latency();
        test_ps2_player2();
        test_random();
        test_coin();
        test_pause();
        test_download();
        test_reset_async();
        test_autofire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_keyjoy.md
# jtframe_keyjoy

Parametrised player-input conditioner between the MiSTer HPS keyboard/joystick feed and a core's game module. It merges PS/2 key events with up to four 16-bit joystick words into registered active-low game controls. It also provides one-shot coin pulses, a toggled run/pause line and optional per-player autofire. It replaces the per-core ad hoc key/joystick glue in each `*_mister.sv` top.

## Interface
Parameters:
- `PLAYERS`, 2, number of players, legal 1–4
- `BUTTONS`, 2, fire buttons per player, legal 1–6
- `COIN_LEN`, 16'd4800, coin pulse length in `clk` cycles (100 µs at 48 MHz), legal 1–65535
- `AF_DIV`, 20'd400000, autofire half-period in `clk` cycles, legal 2–2^20-1

Ports:
- `clk` in 1: system clock, 48 MHz
- `rst_n` in 1: asynchronous active-low reset
- `ps2_key` in 11: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
- `joy` in 16*PLAYERS: player p at [16p+15:16p]; bit0 R, 1 L, 2 D, 3 U, 4..4+BUTTONS-1 fire, 10 start, 11 coin, 12 pause
- `downloading` in 1: ROM load in progress
- `soft_rst` in 1: OSD/button reset request
- `af_en` in PLAYERS: per-player autofire enable, used only with the macro defined
- `joystick` out (4+BUTTONS)*PLAYERS: active-low {fire[BUTTONS-1:0], U, D, L, R} per player
- `start_n` out PLAYERS: active-low start
- `coin_n` out PLAYERS: active-low coin pulse
- `service_n` out 1: active-low test/service (F5)
- `game_run` out 1: 1 = running, 0 = paused

## Operation
- PS/2 decode: when `ps2_key[10]` differs from its registered copy, latch `ps2_key[9]` into the key addressed by `ps2_key[7:0]`.
- Player 1 keys: arrows 75/72/6B/74; fire0 14 (Ctrl), fire1 11 (Alt), fire2 29 (Space); start 05 (F1); coin 04 (F3); pause 0C (F4); service 03 (F5).
- Player 2 keys: U 2D (R), D 2B (F), L 23 (D), R 34 (G); fire0 1C (A), fire1 1B (S); start 06 (F2); coin 2E (5).
- Keys mapped to players ≥ PLAYERS and unmapped codes are ignored.
- Per control, the active level is `~(key | joy bit)`.
- Coin: a 0→1 edge of the merged coin request loads a per-player 16-bit counter with `COIN_LEN`. `coin_n` is 0 while the counter is nonzero. Edges arriving while the counter is nonzero are ignored. A held request produces exactly one pulse.
- Pause: a 0→1 edge of the merged pause request (any player) toggles `game_run`.
- `soft_rst` forces `game_run`=1 and has priority over a simultaneous toggle edge.
- Download: while `downloading`=1, all active-low outputs are 1, coin counters clear, `game_run`=0, and key latches clear. On deassert, `game_run` returns to 1.
- Reset values: all active-low outputs, key latches and edge registers = 1/0 inactive; counters 0; `game_run`=1.

## Timing
- `joy` to outputs: 1 cycle (one output register).
- PS/2 event to output: 2 cycles (strobe compare, then key latch; the output register is fed combinationally from the latch).
- Coin: `coin_n` falls 1 cycle after the request edge and stays low exactly `COIN_LEN` cycles.
- Pause: `game_run` toggles 1 cycle after the edge.
- `rst_n` assertion mid-pulse clears immediately (asynchronous). Release is synchronous to `clk` through a 2-flop synchroniser inside the block.

## Configuration
- `JTFRAME_AUTOFIRE_EN` defined: a free-running 20-bit counter wraps at `AF_DIV`-1 and toggles a shared phase bit.
  - For each player with `af_en[p]`=1 and fire0 requested, output fire0 = `~phase`.
  - When released, fire0 is 1 within 1 cycle.
- `JTFRAME_AUTOFIRE_EN` undefined: no counter is synthesised, `af_en` is unused, and fire0 passes straight through.

## Structure
- Package `jtframe_keyjoy_pkg`: scan-code localparams, joystick bit-index constants, `ctrl_t` per-player struct {fire, up, down, left, right, start, coin, pause}.
- Sub-module `jtframe_keyjoy_coin`: one per player, holding the edge detect and `COIN_LEN` counter.

## Test plan
- `joy[3]`=1 for player 1 → `joystick[3]`=0 after 1 cycle; release → 1 after 1 cycle.
- `ps2_key`={toggle flip, 1, 0, 8'h2D} with PLAYERS=2 → player 2 U low 2 cycles later; same event with PLAYERS=1 → no output change.
- F3 held 20000 cycles, COIN_LEN=4800 → `coin_n[0]` low for exactly 4800 cycles, one pulse. Second press at cycle 3000 → no extension.
- Pause edge → `game_run`=0. Second edge → 1. Edge coincident with `soft_rst` → 1.
- `downloading`=1 while a coin pulse is active and the up arrow is held → all outputs 1 and `game_run`=0. Release → `game_run`=1, keys cleared.
- With `JTFRAME_AUTOFIRE_EN`, AF_DIV=10, `af_en[0]`=1, fire0 held → fire0 output has period 20 cycles. With `af_en[0]`=0 → steady 0.
